// File: rtl/spi_regif_burst.sv
// SPI slave register interface: oversampled SCLK/CS/MOSI, any CPOL/CPHA,
// 8-bit command byte followed by auto-incrementing DATA_W-bit burst words.
module spi_regif_burst #(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int SH_W  = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W = $clog2(SH_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
  localparam logic IDLE_LVL    = 1'(CPOL);
  localparam logic SAMPLE_LEAD = (CPHA == 0);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q;
  logic                   cs_armed;
  logic                   rd_pend;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SH_W-1:0]        shreg;

  logic              sclk_s, cs_s, mosi_s;
  logic              lead_edge, trail_edge, sample_edge, launch_edge;
  logic [7:0]        cmd_byte;
  logic [DATA_W-1:0] word;
  logic              unused_bits;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge   = (sclk_s != IDLE_LVL) && (sclk_q == IDLE_LVL);
  assign trail_edge  = (sclk_s == IDLE_LVL) && (sclk_q != IDLE_LVL);
  assign sample_edge = SAMPLE_LEAD ? lead_edge  : trail_edge;
  assign launch_edge = SAMPLE_LEAD ? trail_edge : lead_edge;

  assign cmd_byte    = {shreg[6:0], mosi_s};
  assign word        = {shreg[DATA_W-2:0], mosi_s};
  assign unused_bits = ^{cmd_byte, shreg};

  assign miso = (state == RD) && shreg[DATA_W-1];

  // NOTE: mosi is synchronised with the same depth as sclk so the bit seen on
  // an edge-detect cycle is the one that was on the pin at that SCLK edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      cs_armed  <= 1'b0;
      rd_pend   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      // NOTE: strobes default low here and are raised below, so each is
      // exactly one clk wide without any separate clearing logic.
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
      rd_pend   <= rd_en;

      if (wr_en)   addr     <= addr + 1'b1;
      if (cs_s)    cs_armed <= 1'b1;
      if (rd_pend) shreg    <= SH_W'(rd_data);

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          // After reset a high cs must be seen before a frame may start.
          if (!cs_s && cs_armed) begin
            state <= CMD;
            busy  <= 1'b1;
            shreg <= '0;
          end
        end

        default: begin
          // A sample edge in the same clk as cs rising is finished first.
          if (cs_s && !sample_edge) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            if (state == CMD || bit_cnt != '0) frame_err <= 1'b1;
          end else if (sample_edge) begin
            case (state)
              CMD: begin
                if (bit_cnt == CMD_LAST) begin
                  bit_cnt <= '0;
                  addr    <= cmd_byte[ADDR_W-1:0];
                  shreg   <= '0;
                  if (cmd_byte[7]) begin
                    state <= RD;
                    rd_en <= 1'b1;
                  end else begin
                    state <= WR;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  shreg   <= {shreg[SH_W-2:0], mosi_s};
                end
              end
              WR: begin
                if (bit_cnt == WORD_LAST) begin
                  bit_cnt <= '0;
                  wr_data <= word;
                  wr_en   <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  shreg   <= {shreg[SH_W-2:0], mosi_s};
                end
              end
              RD: begin
                if (bit_cnt == WORD_LAST) begin
                  bit_cnt <= '0;
                  addr    <= addr + 1'b1;
                  rd_en   <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              default: ;
            endcase
          end else if (launch_edge && state == RD && bit_cnt != '0 && !rd_pend) begin
            // The first launch edge of a word is skipped so the MSB stays on miso.
            shreg <= shreg << 1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regif_burst.sv
// Bench for spi_regif_burst: one instance per SPI mode, bit-banged master,
// register-file model and a scoreboard of expected wr_en/rd_en events.
module tb_spi_regif_burst;

  localparam int H = 8;  // clk cycles per SCLK phase

  typedef struct {
    int         mode;
    bit         wr;
    logic [1:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk_v = 4'b1100;
  logic [3:0] cs_v   = 4'b1111;
  logic [3:0] mosi_v = 4'b0000;
  logic [7:0] rd_data_v [4];
  logic [7:0] regs [4][4];

  wire [3:0] miso_v, wr_en_v, rd_en_v, busy_v, ferr_v;
  wire [1:0] addr_v    [4];
  wire [7:0] wr_data_v [4];

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  ferr_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_regif_burst #(
      .ADDR_W(2), .DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk_v[g]),
      .cs       (cs_v[g]),
      .mosi     (mosi_v[g]),
      .miso     (miso_v[g]),
      .addr     (addr_v[g]),
      .wr_data  (wr_data_v[g]),
      .wr_en    (wr_en_v[g]),
      .rd_en    (rd_en_v[g]),
      .rd_data  (rd_data_v[g]),
      .busy     (busy_v[g]),
      .frame_err(ferr_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register file with one-cycle read latency.
  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (wr_en_v[m]) regs[m][addr_v[m]] <= wr_data_v[m];
      if (rd_en_v[m]) rd_data_v[m] <= regs[m][addr_v[m]];
    end
  end

  always @(negedge clk) begin
    ev_t e;
    for (int m = 0; m < 4; m++) begin
      if (ferr_v[m]) ferr_cnt[m]++;
      if (wr_en_v[m] || rd_en_v[m]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_event_m%0d", m), 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("ev_mode", 32'(m), 32'(e.mode));
          check("ev_kind", 32'(wr_en_v[m]), 32'(e.wr));
          check("ev_addr", 32'(addr_v[m]), 32'(e.addr));
          if (e.wr) check("ev_data", 32'(wr_data_v[m]), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits of val MSB-first in mode m; rx collects miso on sample edges.
  task automatic xfer(input int m, input logic [31:0] val, input int n, output logic [31:0] rx);
    logic cpol = 1'((m / 2) == 1);
    logic cpha = 1'((m % 2) == 1);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi_v[m] = val[i];
        wait_clks(H);
        rx = {rx[30:0], miso_v[m]};
        sclk_v[m] = ~cpol;
        wait_clks(H);
        sclk_v[m] = cpol;
      end else begin
        sclk_v[m] = ~cpol;
        mosi_v[m] = val[i];
        wait_clks(H);
        rx = {rx[30:0], miso_v[m]};
        sclk_v[m] = cpol;
        wait_clks(H);
      end
    end
  endtask

  task automatic cs_lo(input int m);
    cs_v[m] = 1'b0;
    wait_clks(H);
  endtask

  task automatic cs_hi(input int m);
    wait_clks(H);
    cs_v[m] = 1'b1;
    wait_clks(4 * H);
  endtask

  task automatic push_ev(input int m, input bit wr, input logic [1:0] a, input logic [7:0] d);
    ev_t e;
    e.mode = m; e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wr_frame(input int m, input logic [7:0] cmd, input int nw,
                          input logic [7:0] w0, input logic [7:0] w1);
    logic [31:0] rx;
    logic [1:0]  a    = cmd[1:0];
    int          base = ferr_cnt[m];
    push_ev(m, 1'b1, a, w0);
    if (nw > 1) push_ev(m, 1'b1, a + 2'd1, w1);
    cs_lo(m);
    xfer(m, 32'(cmd), 8, rx);
    check("busy_mid", 32'(busy_v[m]), 32'd1);
    xfer(m, 32'(w0), 8, rx);
    if (nw > 1) xfer(m, 32'(w1), 8, rx);
    cs_hi(m);
    check("busy_idle", 32'(busy_v[m]), 32'd0);
    check("ferr_none", 32'(ferr_cnt[m] - base), 32'd0);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Two-word read; the final word also prefetches the following address.
  task automatic rd_frame(input int m, input logic [7:0] cmd,
                          input logic [7:0] e0, input logic [7:0] e1);
    logic [31:0] rx;
    logic [1:0]  a = cmd[1:0];
    push_ev(m, 1'b0, a, 8'h00);
    push_ev(m, 1'b0, a + 2'd1, 8'h00);
    push_ev(m, 1'b0, a + 2'd2, 8'h00);
    cs_lo(m);
    xfer(m, 32'(cmd), 8, rx);
    xfer(m, 32'h0, 8, rx);
    check($sformatf("rx0_m%0d", m), rx, 32'(e0));
    xfer(m, 32'h0, 8, rx);
    check($sformatf("rx1_m%0d", m), rx, 32'(e1));
    cs_hi(m);
    check("sb_drain_rd", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] rx;
    int          base;

    rst = 1'b1;
    wait_clks(5);
    for (int m = 0; m < 4; m++) begin
      check("rst_addr",  32'(addr_v[m]),    32'd0);
      check("rst_wdata", 32'(wr_data_v[m]), 32'd0);
      check("rst_wr_en", 32'(wr_en_v[m]),   32'd0);
      check("rst_rd_en", 32'(rd_en_v[m]),   32'd0);
      check("rst_busy",  32'(busy_v[m]),    32'd0);
      check("rst_ferr",  32'(ferr_v[m]),    32'd0);
      check("rst_miso",  32'(miso_v[m]),    32'd0);
    end
    rst = 1'b0;
    wait_clks(4 * H);

    for (int m = 0; m < 4; m++) begin
      wr_frame(m, 8'h02, 1, 8'hA5, 8'h00);
      wr_frame(m, 8'h03, 2, 8'h11, 8'h22);
      wr_frame(m, 8'h01, 2, 8'h3C, 8'hC3);
      rd_frame(m, 8'h81, 8'h3C, 8'hC3);
    end

    // cs rises after 5 data bits: word discarded, one frame_err.
    base = ferr_cnt[1];
    cs_lo(1);
    xfer(1, 32'h00, 8, rx);
    xfer(1, 32'h15, 5, rx);
    cs_hi(1);
    check("partial_data_ferr", 32'(ferr_cnt[1] - base), 32'd1);
    check("partial_data_busy", 32'(busy_v[1]), 32'd0);

    // cs rises inside the command byte.
    base = ferr_cnt[2];
    cs_lo(2);
    xfer(2, 32'h8, 4, rx);
    cs_hi(2);
    check("partial_cmd_ferr", 32'(ferr_cnt[2] - base), 32'd1);
    check("partial_cmd_busy", 32'(busy_v[2]), 32'd0);
    check("partial_sb_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-burst with cs held low.
    push_ev(1, 1'b1, 2'd0, 8'h5A);
    cs_lo(1);
    xfer(1, 32'h00, 8, rx);
    xfer(1, 32'h5A, 8, rx);
    xfer(1, 32'h3, 3, rx);
    rst = 1'b1;
    #1;
    check("midrst_addr",  32'(addr_v[1]),    32'd0);
    check("midrst_wdata", 32'(wr_data_v[1]), 32'd0);
    check("midrst_busy",  32'(busy_v[1]),    32'd0);
    check("midrst_wr_en", 32'(wr_en_v[1]),   32'd0);
    check("midrst_miso",  32'(miso_v[1]),    32'd0);
    wait_clks(3);
    rst = 1'b0;
    xfer(1, 32'hFFFF, 16, rx);
    check("postrst_busy", 32'(busy_v[1]), 32'd0);
    check("postrst_sb_drain", 32'(exp_q.size()), 32'd0);
    cs_hi(1);
    wr_frame(1, 8'h02, 1, 8'h77, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
